// File: rtl/dist_disp_pkg.sv
// Shared constants, segment codes and converter state type for the distance display.
// Segment codes are active-low with dp in bit 7 (always off).
package dist_disp_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIST_W = 14;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned MAX_MM = 9999;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_state_e;

    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        logic [7:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dist_seg_display_if.sv
// Distance input and display/status outputs of the seven-segment display block.
// The slave modport is the display's view; master is the upstream/driver view.
interface dist_seg_display_if;
    import dist_disp_pkg::*;

    logic [DIST_W-1:0] distance;
    logic [7:0]        seg;
    logic [3:0]        an;
    logic              busy;
    logic              ovr;

    modport master (
        output distance,
        input  seg,
        input  an,
        input  busy,
        input  ovr
    );

    modport slave (
        input  distance,
        output seg,
        output an,
        output busy,
        output ovr
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit to 4-digit BCD double-dabble: one add-3/shift step per clock.
// IDLE -> SHIFT (14 steps) -> DONE -> IDLE; bcd is valid while done is high.
module bin2bcd_seq
    import dist_disp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIST_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int unsigned SH_W  = BCD_W + DIST_W;
    localparam int unsigned CNT_W = $clog2(DIST_W);

    fsm_state_e       state_q, state_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] adj;
    logic [3:0]       nib;

    always_comb begin
        adj = '0;
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib = sh_q[DIST_W + 4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sh_d    = {{BCD_W{1'b0}}, din};
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                sh_d  = {adj, sh_q[DIST_W-1:0]} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIST_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign bcd  = sh_q[SH_W-1:DIST_W];

endmodule

// File: rtl/dist_seg_display.sv
// Distance-to-BCD conversion and 4-digit multiplexed common-anode display driver.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero one.
module dist_seg_display
    import dist_disp_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    dist_seg_display_if.slave dif
);

    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic              conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic [DIST_W-1:0] last_q, last_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic              ovr_q, ovr_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              tick;
    logic [1:0]        idx_q, idx_d, idx_nx;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        nibble;
    logic [7:0]        seg_sel;

    assign conv_start = !conv_busy && (dif.distance != last_q);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .din   (dif.distance),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // disp and ovr change together so the scan never sees a half-updated value
    always_comb begin
        last_d = last_q;
        disp_d = disp_q;
        ovr_d  = ovr_q;
        if (conv_start) begin
            last_d = dif.distance;
        end
        if (conv_done) begin
            disp_d = conv_bcd;
            ovr_d  = (last_q > DIST_W'(MAX_MM));
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank;

    always_comb begin
        blank    = '0;
        blank[3] = (disp_q[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    end
`endif

    assign tick   = (presc_q == PRE_W'(SCAN_DIV - 1));
    assign idx_nx = idx_q + 2'd1;

    always_comb begin
        nibble = '0;
        unique case (idx_nx)
            2'd0: nibble = disp_q[3:0];
            2'd1: nibble = disp_q[7:4];
            2'd2: nibble = disp_q[11:8];
            2'd3: nibble = disp_q[15:12];
            default: nibble = '0;
        endcase
        seg_sel = seg_decode(nibble);
`ifdef LEADING_ZERO_BLANK_EN
        if (blank[idx_nx]) begin
            seg_sel = SEG_BLANK;
        end
`endif
        if (ovr_q) begin
            seg_sel = SEG_DASH;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_nx;
            an_d    = ~(4'b0001 << idx_nx);
            seg_d   = seg_sel;
        end
    end

    // idx resets to 3 so the first tick lands on digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= '0;
            disp_q  <= '0;
            ovr_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= 2'd3;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
        end else begin
            last_q  <= last_d;
            disp_q  <= disp_d;
            ovr_q   <= ovr_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign dif.seg  = seg_q;
    assign dif.an   = an_q;
    assign dif.busy = conv_busy;
    assign dif.ovr  = ovr_q;

endmodule

// File: tb/tb_dist_seg_display.sv
// Scoreboarded bench for dist_seg_display: stimulus queues expected conversions,
// a monitor checks completion timing, ovr and every scanned digit against a decimal model.
module tb_dist_seg_display;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned SCAN_HZ  = 250;
    localparam int          SCAN_DIV = 4;

    typedef struct {
        int val;
        int done;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   last_applied = 0;
    exp_t sb[$];

    logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         pow10   [4]  = '{1, 10, 100, 1000};

    dist_seg_display_if dif ();

    dist_seg_display #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] ref_seg(input int v, input int k);
        int d;
        if (v > 9999) return 8'hBF;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && v < pow10[k]) return 8'hFF;
`endif
        d = (v / pow10[k]) % 10;
        return seg_lut[d];
    endfunction

    // Monitor: scan sequence/timing and conversion completions.
    initial begin
        int         exp_idx;
        int         cur_val;
        int         since;
        bit         first_tick;
        logic       prev_busy;
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        exp_t       e;
        exp_idx = 3; cur_val = 0; since = 0; first_tick = 1; prev_busy = 0; prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_idx = 3; cur_val = 0; since = 0; first_tick = 1;
                prev_busy = 0; prev_an = 4'hF;
            end else begin
                since++;
                if (dif.an != prev_an) begin
                    exp_idx = (exp_idx + 1) % 4;
                    exp_an  = ~(4'b0001 << exp_idx);
                    check($sformatf("an d%0d", exp_idx), int'(dif.an), int'(exp_an));
                    check($sformatf("seg d%0d v%0d", exp_idx, cur_val), int'(dif.seg),
                          int'(ref_seg(cur_val, exp_idx)));
                    if (!first_tick) check("scan_period", since, SCAN_DIV);
                    first_tick = 0;
                    since      = 0;
                    prev_an    = dif.an;
                end else if (!first_tick && since > SCAN_DIV) begin
                    check("scan_stall", since, SCAN_DIV);
                    since = 0;
                end
                if (prev_busy && !dif.busy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: busy fell with no conversion pending");
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("done_cycle v%0d", e.val), cyc, e.done);
                        check($sformatf("ovr v%0d", e.val), int'(dif.ovr), int'(e.val > 9999));
                        cur_val = e.val;
                    end
                end
                prev_busy = dif.busy;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || dif.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        sb.delete();
        repeat (4 * SCAN_DIV + 2) @(negedge clk);
    endtask

    task automatic apply(input int v);
        @(posedge clk);
        #1;
        dif.distance = 14'(v);
        if (v != last_applied) sb.push_back('{val: v, done: cyc + 16});
        last_applied = v;
    endtask

    initial begin
        int t0;
        int v;
        int dir [8] = '{1234, 10000, 9999, 7, 0, 16383, 1000, 10};

        dif.distance = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst seg", int'(dif.seg), 'hFF);
        check("rst an", int'(dif.an), 'hF);
        check("rst busy", int'(dif.busy), 0);
        check("rst ovr", int'(dif.ovr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_tick an", int'(dif.an), 'hF);
        check("pre_tick seg", int'(dif.seg), 'hFF);
        repeat (4 * SCAN_DIV + 2) @(negedge clk);

        foreach (dir[i]) begin
            apply(dir[i]);
            drain();
        end

        // change during SHIFT is held off until the FSM returns to IDLE
        @(posedge clk);
        #1;
        dif.distance = 14'd100;
        t0 = cyc;
        sb.push_back('{val: 100, done: t0 + 16});
        repeat (5) @(posedge clk);
        #1;
        dif.distance = 14'd200;
        sb.push_back('{val: 200, done: t0 + 32});
        last_applied = 200;
        drain();

        // reset mid-conversion aborts; the held distance is re-converted afterwards
        @(posedge clk);
        #1;
        dif.distance = 14'd4321;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort busy", int'(dif.busy), 0);
        check("abort seg", int'(dif.seg), 'hFF);
        check("abort an", int'(dif.an), 'hF);
        check("abort ovr", int'(dif.ovr), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.push_back('{val: 4321, done: cyc + 16});
        last_applied = 4321;
        drain();

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 999);
                2:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 16383);
            endcase
            if (v == last_applied) v = (v + 1) % 16384;
            apply(v);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dist_seg_display.md
# dist_seg_display

Downstream consumer of the ultrasonic ranging stage. Takes the 14-bit filtered obstacle distance in millimetres and converts it to four BCD digits with a sequential double-dabble converter. Drives a 4-digit multiplexed common-anode seven-segment display. Values above 9999 mm are flagged as over-range.

## Interface
- `CLK_HZ`, 100_000_000, clk frequency in Hz.
- `SCAN_HZ`, 1000, per-digit scan rate in Hz. `SCAN_DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- Clock is clk; reset rst_n is asynchronous, active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  async active-low reset.
- `distance`  in  14  distance in mm, synchronous to clk, unsigned.
- `seg`  out  8  segment drive, active-low: [7]=dp, [6:0]=g..a.
- `an`  out  4  digit enables, active-low; an[0] is the ones (rightmost) digit.
- `busy`  out  1  high while a conversion is in progress.
- `ovr`  out  1  high when the displayed value is over-range (>9999).

## Operation
- Keep `last` (14 b, reset 0). In IDLE, `distance != last` starts a conversion: `last` <= distance, shift register <= {16'b0, distance}.
- FSM states:
  - IDLE -> SHIFT on change detect.
  - SHIFT runs 14 iterations (add-3 to each BCD nibble ≥5, then shift left 1), then goes to DONE.
  - DONE -> IDLE.
- In DONE, `disp` (16 b BCD) and `ovr` update atomically. The scan path reads only `disp`, so a partial conversion is never displayed.
- Over-range: if `last > 9999`, set `ovr=1`; all digits show a dash (g segment only, 8'hBF). Otherwise `ovr=0`.
- Distance changes during SHIFT/DONE are ignored. When the FSM is back in IDLE, the compare against `last` re-triggers on the next cycle if the input differs.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; the terminal count produces a 1-cycle tick.
  - On a tick, the digit index (2 b) advances mod 4 (0->1->2->3->0). The first tick after reset selects digit 0.
  - `an` and `seg` are registered and update on the same edge.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF. dp is always off.
- Reset values:
  - seg=8'hFF, an=4'hF, busy=0, ovr=0.
  - disp=0, last=0, FSM=IDLE, prescaler=0.
- Async reset mid-conversion aborts the conversion. After release, the current distance is re-converted if it is nonzero.

## Timing
- Edge T: IDLE samples distance ≠ last.
- Edges T+1..T+14: SHIFT, with busy=1 from T+1.
- Edge T+15: DONE, disp/ovr valid, busy still 1. Edge T+16: IDLE, busy=0.
- Latency from input change to `disp` is 15 clocks; the new value reaches `seg` at the next scan tick for each digit.
- Full display refresh = 4·SCAN_DIV clocks (4 ms at defaults).
- Back-to-back conversions: minimum 16 clocks apart.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: digits above the most significant nonzero digit show blank (8'hFF). Digit 0 is always shown, so 0 displays as "   0". Dashes are unaffected.
  - Undefined: all four digits are always shown ("0007").

## Structure
- Package `dist_disp_pkg` holds:
  - constant `DIGITS=4`;
  - segment code constants `SEG_0..SEG_9`, `SEG_DASH`, `SEG_BLANK`;
  - the FSM state enum `{IDLE, SHIFT, DONE}`;
  - `MAX_MM=9999`.
- One sub-module, `bin2bcd_seq`: a 14-bit to 4-digit BCD sequential double-dabble with start/busy/done. The top module holds change detect, over-range, prescaler, digit mux and the segment decoder.

## Test plan
- Reset held, then released with distance=0 -> seg=FF, an=F, busy=0, ovr=0 until the first tick; then an=1110, seg=C0.
- CLK_HZ=1000, SCAN_HZ=250 (SCAN_DIV=4); distance=1234 -> busy=1 at T+1..T+15, disp=16'h1234 at T+15; scan shows an 1110/99, 1101/B0, 1011/A4, 0111/F9.
- distance=10000 -> ovr=1; all four digits show BF. Then distance=9999 -> ovr=0, digits show 90.
- distance=7 -> with `LEADING_ZERO_BLANK_EN`: digits 3..1 show FF, digit 0 shows F8; without it: C0,C0,C0,F8.
- distance 100 -> 200 at T+5 -> disp=0x0100 at T+15, then a new conversion starts at T+16, busy drops at T+32, and disp=0x0200 at T+31.
- rst_n pulsed low at T+7 of a 4321 conversion -> immediately busy=0, seg=FF, an=F, disp=0; after release, the conversion restarts and disp=0x4321 15 clocks later.
